// File: rtl/dispatcher_pkg.sv
// Shared dispatcher definitions: chunk/lane geometry, the unrolling-factor code and the
// lane/bit to thread-ID offset mapping. The mapper's verification model reuses the mapping.
package dispatcher_pkg;

  localparam int unsigned CHUNK_W     = 256;
  localparam int unsigned LANE_MASK_W = 64;
  localparam int unsigned NUM_LANES   = 4;

  typedef enum logic [1:0] {
    UNROLL_1 = 2'd0,
    UNROLL_2 = 2'd1,
    UNROLL_4 = 2'd2
  } unroll_e;

  // Code 3 is not a legal factor; it behaves like factor 1.
  function automatic unroll_e decode_unroll(logic [1:0] code);
    unroll_e res;
    case (code)
      2'd1:    res = UNROLL_2;
      2'd2:    res = UNROLL_4;
      default: res = UNROLL_1;
    endcase
    return res;
  endfunction

  // Offset of lane-mask bit b within its 256-thread chunk. Every field lands in its own bit
  // range, so the offset is a pure bit concatenation and adding it to a chunk base is an OR.
  function automatic logic [7:0] tid_offset(logic [1:0] lane, unroll_e unroll, logic [5:0] b);
    logic [7:0] off;
    case (unroll)
      UNROLL_2: off = {lane[1], b[5:4], lane[0], b[3:0]};
      UNROLL_4: off = {b[5:3], lane, b[2:0]};
      default:  off = {lane, b};
    endcase
    return off;
  endfunction

endpackage

// File: rtl/lane_tid_sequencer_if.sv
// Load and emit handshake bundle of one lane thread-ID sequencer.
//   master: upstream mapper + downstream consumer side (drives loads, flush, out_ready)
//   slave : the sequencer (drives in_ready, out_valid, out_tid, out_last, empty_done)
interface lane_tid_sequencer_if #(
  parameter int unsigned TID_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_mask;
  logic [TID_W-1:0] in_base_tid;
  logic [1:0]       in_unroll;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [TID_W-1:0] out_tid;
  logic             out_last;
  logic             empty_done;

  modport master (
    output in_valid, in_mask, in_base_tid, in_unroll, flush, out_ready,
    input  in_ready, out_valid, out_tid, out_last, empty_done
  );

  modport slave (
    input  in_valid, in_mask, in_base_tid, in_unroll, flush, out_ready,
    output in_ready, out_valid, out_tid, out_last, empty_done
  );
endinterface

// File: rtl/lsb_prio_enc64.sv
// 64-bit lowest-set-bit priority encoder.
//   vec            : input vector
//   idx            : index of the lowest set bit (0 when vec is zero)
//   any            : vec has at least one bit set
//   one_hot_single : vec has exactly one bit set
module lsb_prio_enc64 (
  input  logic [63:0] vec,
  output logic [5:0]  idx,
  output logic        any,
  output logic        one_hot_single
);

  always_comb begin
    idx = '0;
    // Descending scan so the lowest set bit wins.
    for (int i = 63; i >= 0; i--) begin
      if (vec[i]) idx = 6'(i);
    end
  end

  assign any            = |vec;
  // Clearing the lowest set bit leaves nothing only when exactly one bit was set.
  assign one_hot_single = any && ((vec & (vec - 64'd1)) == '0);

endmodule

// File: rtl/lane_tid_sequencer.sv
// Per-lane thread-ID sequencer. Accepts one 64-bit lane mask per load and emits the global
// thread ID of each set bit, lowest first, one per cycle, undoing the mapper's interleave.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load side (in_valid/in_ready/in_mask/in_base_tid/in_unroll), flush,
//                emit side (out_valid/out_ready/out_tid/out_last), empty_done pulse
module lane_tid_sequencer
  import dispatcher_pkg::*;
#(
  parameter int unsigned LANE_ID = 0,
  parameter int unsigned TID_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lane_tid_sequencer_if.slave   bus
);

  localparam logic [1:0] LaneSlot = 2'(LANE_ID);

  typedef enum logic {StIdle, StActive} state_e;

  state_e           state_q;
  logic [63:0]      mask_q;
  logic [TID_W-1:0] base_q;
  unroll_e          unroll_q;
  logic             empty_done_q;

  logic [5:0] bit_idx;
  logic       mask_any;
  logic       mask_single;

  lsb_prio_enc64 u_enc (
    .vec            (mask_q),
    .idx            (bit_idx),
    .any            (mask_any),
    .one_hot_single (mask_single)
  );

  logic active;
  logic fire;
  logic last_fire;
  logic accept;

  // ACTIVE always holds a nonzero mask; the extra term only keeps a corrupted state harmless.
  assign active    = (state_q == StActive) && mask_any;
  assign fire      = active && bus.out_ready;
  assign last_fire = fire && mask_single;
  assign accept    = bus.in_valid && bus.in_ready;

  assign bus.in_ready   = !bus.flush && ((state_q == StIdle) || last_fire);
  assign bus.out_valid  = active;
  assign bus.out_last   = active && mask_single;
  assign bus.empty_done = empty_done_q;
  assign bus.out_tid    = active ? (base_q | TID_W'(tid_offset(LaneSlot, unroll_q, bit_idx)))
                                 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      base_q       <= '0;
      unroll_q     <= UNROLL_1;
      empty_done_q <= 1'b0;
    end else begin
      empty_done_q <= 1'b0;
      if (bus.flush) begin
        state_q <= StIdle;
        mask_q  <= '0;
      end else if (accept) begin
        // Covers both an idle load and a load on the final fire of the previous mask.
        mask_q   <= bus.in_mask;
        base_q   <= bus.in_base_tid;
        unroll_q <= decode_unroll(bus.in_unroll);
        if (|bus.in_mask) begin
          state_q <= StActive;
        end else begin
          state_q      <= StIdle;
          empty_done_q <= 1'b1;
        end
      end else if (fire) begin
        mask_q <= mask_q & (mask_q - 64'd1);
        if (mask_single) state_q <= StIdle;
      end
    end
  end

endmodule
